// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states, lane widths.
// Build option LSU_MISALIGNED_SPLIT_EN widens the lane paths to two bus words.
package lsu_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam int LANE_BYTES = 8;
`else
    localparam int LANE_BYTES = 4;
`endif
    localparam int LANE_BITS = 8 * LANE_BYTES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_RESP
    } lsu_state_e;

    function automatic logic f3_legal(input logic write, input logic [2:0] funct3);
        if (write)
            return funct3 inside {LS_B, LS_H, LS_W};
        return funct3 inside {LS_B, LS_H, LS_W, LS_BU, LS_HU};
    endfunction

    // Natural alignment: the byte offset is a multiple of the access size.
    function automatic logic f3_aligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b00:   return TRUE;
            2'b01:   return ~off[0];
            default: return (off == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane aligner: byte enables and write-data positioning for a store,
// and shift plus sign/zero extension of the returned lanes for a load.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]            i_funct3,
    input  logic [1:0]            i_off,
    input  logic [31:0]           i_wdata,
    input  logic [LANE_BITS-1:0]  i_rdata,
    output logic [LANE_BYTES-1:0] o_be,
    output logic [LANE_BITS-1:0]  o_wdata,
    output logic [31:0]           o_rdata
);

    logic [3:0]  w_mask;
    logic [4:0]  w_shamt;
    logic [31:0] w_rword;

    always_comb begin
        // NOTE: every signal written in a combinational block gets a default first, so no path infers a latch.
        w_mask = 4'b0001;
        case (i_funct3[1:0])
            2'b01:   w_mask = 4'b0011;
            2'b10:   w_mask = 4'b1111;
            default: ;
        endcase
    end

    assign w_shamt = {i_off, 3'b000};
    assign o_be    = LANE_BYTES'(w_mask) << i_off;
    assign o_wdata = LANE_BITS'(i_wdata) << w_shamt;
    assign w_rword = 32'(i_rdata >> w_shamt);

    always_comb begin
        o_rdata = w_rword;
        case (i_funct3)
            LS_B:    o_rdata = {{24{w_rword[7]}}, w_rword[7:0]};
            LS_BU:   o_rdata = {24'h0, w_rword[7:0]};
            LS_H:    o_rdata = {{16{w_rword[15]}}, w_rword[15:0]};
            LS_HU:   o_rdata = {16'h0, w_rword[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit between the MEM stage and a handshaked word-organised data bus.
// Build option LSU_MISALIGNED_SPLIT_EN: word-crossing accesses become two bus beats instead of errors.
module lsu
    import lsu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_e r_state, w_state_next;

    logic        r_write;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic                  w_accept;
    logic                  w_bad;
    logic [2:0]            w_funct3;
    logic [1:0]            w_off;
    logic [31:0]           w_wdata;
    logic [LANE_BYTES-1:0] w_be;
    logic [LANE_BITS-1:0]  w_wlanes;
    logic [LANE_BITS-1:0]  w_rlanes;
    logic [31:0]           w_rdata_ext;

    logic        w_mem_req_n;
    logic        w_mem_we_n;
    logic [31:0] w_mem_addr_n;
    logic [3:0]  w_mem_be_n;
    logic [31:0] w_mem_wdata_n;
    logic        w_resp_err_n;
    logic [31:0] w_resp_rdata_n;

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic        r_split;
    logic [31:0] r_word0;
    logic        w_split;
    logic [31:0] w_word1_addr;
`endif

    assign req_ready = (r_state == S_IDLE);
    assign w_accept  = req_valid && req_ready;

    // In IDLE the aligner sees the live request so the first bus beat registers on accept.
    assign w_funct3 = req_ready ? req_funct3    : r_funct3;
    assign w_off    = req_ready ? req_addr[1:0] : r_addr[1:0];
    assign w_wdata  = req_ready ? req_wdata     : r_wdata;

`ifdef LSU_MISALIGNED_SPLIT_EN
    assign w_split      = |w_be[7:4];
    assign w_word1_addr = {r_addr[31:2], 2'b00} + 32'd4;
    assign w_bad        = !f3_legal(req_write, req_funct3);
    assign w_rlanes     = (r_state == S_WAIT1) ? {mem_rdata, r_word0} : {32'h0, mem_rdata};
`else
    assign w_bad    = !f3_legal(req_write, req_funct3) || !f3_aligned(req_funct3, req_addr[1:0]);
    assign w_rlanes = mem_rdata;
`endif

    lsu_align u_align (
        .i_funct3 (w_funct3),
        .i_off    (w_off),
        .i_wdata  (w_wdata),
        .i_rdata  (w_rlanes),
        .o_be     (w_be),
        .o_wdata  (w_wlanes),
        .o_rdata  (w_rdata_ext)
    );

    always_comb begin
        w_state_next   = r_state;
        w_mem_we_n     = mem_we;
        w_mem_addr_n   = mem_addr;
        w_mem_be_n     = mem_be;
        w_mem_wdata_n  = mem_wdata;
        w_resp_err_n   = FALSE;
        w_resp_rdata_n = '0;

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_bad) begin
                        w_state_next = S_RESP;
                        w_resp_err_n = TRUE;
                    end else begin
                        w_state_next  = S_REQ0;
                        w_mem_we_n    = req_write;
                        w_mem_addr_n  = {req_addr[31:2], 2'b00};
                        w_mem_be_n    = w_be[3:0];
                        w_mem_wdata_n = w_wlanes[31:0];
                    end
                end
            end
            S_REQ0: begin
                if (mem_gnt) begin
                    w_state_next = r_write ? S_RESP : S_WAIT0;
`ifdef LSU_MISALIGNED_SPLIT_EN
                    if (r_write && r_split) begin
                        w_state_next  = S_REQ1;
                        w_mem_addr_n  = w_word1_addr;
                        w_mem_be_n    = w_be[7:4];
                        w_mem_wdata_n = w_wlanes[63:32];
                    end
`endif
                end
            end
            S_WAIT0: begin
                if (mem_rvalid) begin
                    w_state_next   = S_RESP;
                    w_resp_rdata_n = w_rdata_ext;
`ifdef LSU_MISALIGNED_SPLIT_EN
                    if (r_split) begin
                        w_state_next   = S_REQ1;
                        w_resp_rdata_n = '0;
                        w_mem_addr_n   = w_word1_addr;
                        w_mem_be_n     = w_be[7:4];
                        w_mem_wdata_n  = w_wlanes[63:32];
                    end
`endif
                end
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            S_REQ1: begin
                if (mem_gnt)
                    w_state_next = r_write ? S_RESP : S_WAIT1;
            end
            S_WAIT1: begin
                if (mem_rvalid) begin
                    w_state_next   = S_RESP;
                    w_resp_rdata_n = w_rdata_ext;
                end
            end
`endif
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase

        w_mem_req_n = (w_state_next == S_REQ0) || (w_state_next == S_REQ1);
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state    <= S_IDLE;
            r_write    <= 1'b0;
            r_funct3   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            r_split    <= 1'b0;
            r_word0    <= '0;
`endif
        end else begin
            r_state    <= w_state_next;
            mem_req    <= w_mem_req_n;
            mem_we     <= w_mem_we_n;
            mem_addr   <= w_mem_addr_n;
            mem_be     <= w_mem_be_n;
            mem_wdata  <= w_mem_wdata_n;
            resp_valid <= (w_state_next == S_RESP);
            resp_err   <= w_resp_err_n;
            resp_rdata <= w_resp_rdata_n;
            if (w_accept) begin
                r_write  <= req_write;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            if (w_accept)
                r_split <= w_split;
            if (r_state == S_WAIT0 && mem_rvalid)
                r_word0 <= mem_rdata;
`endif
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus queues expected responses and bus beats,
// a monitor and a bus model pop and compare them as the DUT presents them.
module tb_lsu;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    lsu dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          t;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];
    logic [31:0] mem [logic [31:0]];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_req = 0;
    int gnt_wait = 0;
    int rv_wait = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: event not seen as required (cycle %0d)", name, cyc);
    endtask

    // Response monitor: every resp_valid must match the oldest expectation.
    exp_t e;
    always @(negedge clock) begin
        if (mem_req) n_req++;
        if (!reset && resp_valid) begin
            if (exp_q.size() == 0) begin
                fail("unexpected_resp");
            end else begin
                e = exp_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                check("resp_latency", 32'(cyc - e.t), 32'(e.lat));
            end
        end
    end

    // Bus model: grant after gnt_wait cycles, return read data rv_wait cycles after gnt+1.
    int          gcnt = 0;
    int          rv_cnt = -1;
    logic [31:0] rv_data = '0;
    bus_t        b;
    logic [31:0] word;
    always @(negedge clock) begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0BAD_F00D;
        if (rv_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rv_data;
            rv_cnt     = -1;
        end else if (rv_cnt > 0) begin
            rv_cnt--;
        end
        if (mem_req && !reset) begin
            if (gcnt < gnt_wait) begin
                gcnt++;
            end else begin
                mem_gnt = 1'b1;
                gcnt    = 0;
                if (bus_q.size() == 0) begin
                    fail("unexpected_bus_beat");
                end else begin
                    b = bus_q.pop_front();
                    check("bus_we", {31'h0, mem_we}, {31'h0, b.we});
                    check("bus_addr", mem_addr, b.addr);
                    check("bus_be", {28'h0, mem_be}, {28'h0, b.be});
                    if (b.we) check("bus_wdata", mem_wdata, b.wdata);
                end
                word = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                if (mem_we) begin
                    for (int i = 0; i < 4; i++)
                        if (mem_be[i]) word[8*i +: 8] = mem_wdata[8*i +: 8];
                    mem[mem_addr] = word;
                end else begin
                    rv_data = word;
                    rv_cnt  = rv_wait;
                end
            end
        end else begin
            gcnt = 0;
        end
    end

    task automatic exp_bus(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        bus_q.push_back('{we, addr, be, wd});
    endtask

    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee, input int lat, input bit want);
        int n;
        exp_t x;
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            fail("accept_timeout");
        end else if (want) begin
            x = '{er, ee, lat, cyc};
            exp_q.push_back(x);
        end
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus_q.size() != 0) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) fail("drain_timeout");
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        int n;

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_be", {28'h0, mem_be}, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);

        // Aligned word store then load.
        exp_bus(1, 32'h10, 4'hF, 32'hDEADBEEF);
        issue(1, F_W, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 1); drain();
        exp_bus(0, 32'h10, 4'hF, 32'h0);
        issue(0, F_W, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 1); drain();

        // Byte/half extraction from 0x80FF7F01.
        exp_bus(1, 32'h10, 4'hF, 32'h80FF7F01);
        issue(1, F_W, 32'h10, 32'h80FF7F01, 32'h0, 0, 2, 1); drain();
        exp_bus(0, 32'h10, 4'h8, 32'h0);
        issue(0, F_B, 32'h13, 32'h0, 32'hFFFFFF80, 0, 3, 1); drain();
        exp_bus(0, 32'h10, 4'h8, 32'h0);
        issue(0, F_BU, 32'h13, 32'h0, 32'h00000080, 0, 3, 1); drain();
        exp_bus(0, 32'h10, 4'hC, 32'h0);
        issue(0, F_H, 32'h12, 32'h0, 32'hFFFF80FF, 0, 3, 1); drain();
        exp_bus(0, 32'h10, 4'h3, 32'h0);
        issue(0, F_HU, 32'h10, 32'h0, 32'h00007F01, 0, 3, 1); drain();
        exp_bus(0, 32'h10, 4'h4, 32'h0);
        issue(0, F_B, 32'h12, 32'h0, 32'hFFFFFFFF, 0, 3, 1); drain();
        exp_bus(0, 32'h10, 4'h2, 32'h0);
        issue(0, F_B, 32'h11, 32'h0, 32'h0000007F, 0, 3, 1); drain();

        // Byte store lane placement.
        exp_bus(1, 32'h20, 4'h4, 32'h00AB0000);
        issue(1, F_B, 32'h22, 32'h000000AB, 32'h0, 0, 2, 1); drain();
        exp_bus(0, 32'h20, 4'hF, 32'h0);
        issue(0, F_W, 32'h20, 32'h0, 32'h00AB0000, 0, 3, 1); drain();

`ifdef LSU_MISALIGNED_SPLIT_EN
        exp_bus(1, 32'h20, 4'h6, 32'h00ABCD00);
        issue(1, F_H, 32'h21, 32'h0000ABCD, 32'h0, 0, 2, 1); drain();
        exp_bus(0, 32'h20, 4'hF, 32'h0);
        issue(0, F_W, 32'h20, 32'h0, 32'h00ABCD00, 0, 3, 1); drain();
        exp_bus(0, 32'h10, 4'h6, 32'h0);
        issue(0, F_H, 32'h11, 32'h0, 32'hFFFFFF7F, 0, 3, 1); drain();
`else
        snap = n_req;
        issue(1, F_H, 32'h21, 32'h0000ABCD, 32'h0, 1, 1, 1); drain();
        issue(0, F_H, 32'h11, 32'h0, 32'h0, 1, 1, 1); drain();
        check("misaligned_no_bus", 32'(n_req), 32'(snap));
`endif

        // Illegal funct3: immediate error, no bus request.
        snap = n_req;
        issue(0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1, 1); drain();
        issue(0, 3'b111, 32'h10, 32'h0, 32'h0, 1, 1, 1); drain();
        issue(1, 3'b100, 32'h10, 32'h12345678, 32'h0, 1, 1, 1); drain();
        check("illegal_no_bus", 32'(n_req), 32'(snap));

        // Word-crossing load and store.
        exp_bus(1, 32'h0C, 4'hF, 32'h44332211);
        issue(1, F_W, 32'h0C, 32'h44332211, 32'h0, 0, 2, 1); drain();
        exp_bus(1, 32'h10, 4'hF, 32'h88776655);
        issue(1, F_W, 32'h10, 32'h88776655, 32'h0, 0, 2, 1); drain();
`ifdef LSU_MISALIGNED_SPLIT_EN
        exp_bus(0, 32'h0C, 4'hC, 32'h0);
        exp_bus(0, 32'h10, 4'h3, 32'h0);
        issue(0, F_W, 32'h0E, 32'h0, 32'h66554433, 0, 5, 1); drain();
        exp_bus(1, 32'hFFFFFFFC, 4'h8, 32'h44000000);
        exp_bus(1, 32'h00000000, 4'h7, 32'h00112233);
        issue(1, F_W, 32'hFFFFFFFF, 32'h11223344, 32'h0, 0, 3, 1); drain();
        exp_bus(0, 32'h0, 4'hF, 32'h0);
        issue(0, F_W, 32'h0, 32'h0, 32'h00112233, 0, 3, 1); drain();
`else
        snap = n_req;
        issue(0, F_W, 32'h0E, 32'h0, 32'h0, 1, 1, 1); drain();
        issue(1, F_W, 32'hFFFFFFFF, 32'h11223344, 32'h0, 1, 1, 1); drain();
        check("split_off_no_bus", 32'(n_req), 32'(snap));
`endif

        // Bus wait states add one cycle each.
        gnt_wait = 2; rv_wait = 1;
        exp_bus(0, 32'h10, 4'hF, 32'h0);
        issue(0, F_W, 32'h10, 32'h0, 32'h88776655, 0, 6, 1); drain();
        gnt_wait = 1; rv_wait = 0;
        exp_bus(1, 32'h30, 4'hF, 32'h12345678);
        issue(1, F_W, 32'h30, 32'h12345678, 32'h0, 0, 3, 1); drain();

        // Reset during WAIT0: request dropped, late rvalid ignored.
        gnt_wait = 3; rv_wait = 5;
        exp_bus(0, 32'h10, 4'hF, 32'h0);
        issue(0, F_W, 32'h10, 32'h0, 32'h0, 0, 0, 0);
        n = 0;
        do begin
            @(posedge clock);
            n++;
        end while (!mem_gnt && n < 20);
        if (!mem_gnt) fail("reset_test_gnt_timeout");
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("post_rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("post_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        gnt_wait = 0; rv_wait = 0;
        repeat (6) @(negedge clock);
        check("post_rst_idle", {31'h0, req_ready}, 32'h1);
        exp_bus(0, 32'h10, 4'hF, 32'h0);
        issue(0, F_W, 32'h10, 32'h0, 32'h88776655, 0, 3, 1); drain();

        check("exp_queue_empty", 32'(exp_q.size()), 32'h0);
        check("bus_queue_empty", 32'(bus_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
